// File: rtl/hilo_mult_seq_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: data and counter
// widths, the multiply cycle budget and the controller state encoding.
package hilo_mult_seq_pkg;

  localparam int DATA_W      = 32;
  localparam int CNT_W       = 6;
  localparam int MULT_CYCLES = 33;

  // Counter value on the final RUN cycle (counter starts at 0 on acceptance).
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_mult_seq_if.sv
// Bus bundle between the HI/LO sequencer, its requester and the external
// multiplier. The sequencer takes the slave side; whoever drives requests
// and hosts the multiplier takes the master side.
interface hilo_mult_seq_if;
  import hilo_mult_seq_pkg::*;

  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              mult_ctrl;
  logic [DATA_W-1:0] mult_a;
  logic [DATA_W-1:0] mult_b;
  logic [DATA_W-1:0] mult_hi;
  logic [DATA_W-1:0] mult_lo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;

  modport slave (
    input  start, op_a, op_b, hi_we, lo_we, wdata, mult_hi, mult_lo,
    output mult_ctrl, mult_a, mult_b, hi, lo, busy, done
  );

  modport master (
    output start, op_a, op_b, hi_we, lo_we, wdata, mult_hi, mult_lo,
    input  mult_ctrl, mult_a, mult_b, hi, lo, busy, done
  );

endinterface

// File: rtl/hilo_mult_seq_hilo_reg.sv
// Architectural HI/LO register pair. Each half has its own write enable;
// the reset input clears both synchronously.
module hilo_reg
  import hilo_mult_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hiWe_i,
  input  logic              loWe_i,
  input  logic [DATA_W-1:0] hiData_i,
  input  logic [DATA_W-1:0] loData_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Hold HI and LO, loading each half independently when its enable is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hiWe_i) hi_q <= hiData_i;
      if (loWe_i) lo_q <= loData_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_mult_seq.sv
// HI/LO multiply sequencer. Accepts a signed multiply request while idle,
// holds the operands steady for an external multiplier for a fixed number
// of enabled cycles, then copies the multiplier result into HI/LO and
// pulses done. Direct HI/LO writes are honoured only while idle.
module hilo_mult_seq
  import hilo_mult_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  hilo_mult_seq_if.slave bus
);

  state_t            state_q;
  logic [CNT_W-1:0]  cycleCnt_q;
  logic [DATA_W-1:0] multA_q;
  logic [DATA_W-1:0] multB_q;
  logic              multCtrl_q;
  logic              busy_q;
  logic              done_q;

  logic              hiWe;
  logic              loWe;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_d;

  // Controller: sequences IDLE -> RUN -> CAPTURE and registers the
  // state-derived outputs so they change together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cycleCnt_q <= '0;
      multA_q    <= '0;
      multB_q    <= '0;
      multCtrl_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            multA_q    <= bus.op_a;
            multB_q    <= bus.op_b;
            cycleCnt_q <= '0;
            state_q    <= RUN;
            multCtrl_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          cycleCnt_q <= cycleCnt_q + CNT_W'(1);
          if (cycleCnt_q == RUN_LAST) begin
            state_q    <= CAPTURE;
            multCtrl_q <= 1'b0;
          end
        end
        CAPTURE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          multCtrl_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO write selection: the multiplier result wins in CAPTURE, direct
  // writes are only allowed in IDLE and are dropped while busy.
  always_comb begin
    hiWe = 1'b0;
    loWe = 1'b0;
    hi_d = bus.wdata;
    lo_d = bus.wdata;
    if (state_q == CAPTURE) begin
      hiWe = 1'b1;
      loWe = 1'b1;
      hi_d = bus.mult_hi;
      lo_d = bus.mult_lo;
    end else if (state_q == IDLE) begin
      hiWe = bus.hi_we;
      loWe = bus.lo_we;
    end
  end

  hilo_reg u_hilo_reg (
    .clk      (clk),
    .reset    (reset),
    .hiWe_i   (hiWe),
    .loWe_i   (loWe),
    .hiData_i (hi_d),
    .loData_i (lo_d),
    .hi_o     (bus.hi),
    .lo_o     (bus.lo)
  );

  assign bus.mult_ctrl = multCtrl_q;
  assign bus.mult_a    = multA_q;
  assign bus.mult_b    = multB_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Testbench for hilo_mult_seq: directed and random multiplies, direct
// HI/LO writes, requests while busy, reset mid-operation and back-to-back
// starts, all checked against an arithmetic reference model.
module tb_hilo_mult_seq;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [31:0] modHi;
  logic [31:0] modLo;

  hilo_mult_seq_if bus ();

  hilo_mult_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier model: the product only becomes visible after the
  // full number of enabled edges; before that it presents junk so an early
  // capture is caught.
  logic [63:0] mulRes = 64'hDEAD_BEEF_DEAD_BEEF;
  int          enCnt  = 0;

  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Multiplier behaviour: count enabled edges and load the product on the 33rd.
  always @(posedge clk) begin
    if (bus.mult_ctrl) begin
      if (enCnt == 32) mulRes <= refProduct(bus.mult_a, bus.mult_b);
      else             mulRes <= 64'hDEAD_BEEF_DEAD_BEEF;
      enCnt <= enCnt + 1;
    end else begin
      enCnt <= 0;
    end
  end

  assign bus.mult_hi = mulRes[63:32];
  assign bus.mult_lo = mulRes[31:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [31:0] a, input logic [31:0] b,
                               input logic hw, input logic lw, input logic [31:0] wd);
    bus.start = st;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = wd;
  endtask

  // Runs one multiply; k counts samples after the acceptance edge.
  task automatic runMult(input logic [31:0] a, input logic [31:0] b, input bit preStarted,
                         input bit disturb, input bit chainNext, input logic [31:0] na,
                         input logic [31:0] nb, output int ctrlCycles, output int busyCycles,
                         output int latency);
    ctrlCycles = 0;
    busyCycles = 0;
    latency    = -1;
    if (!preStarted) applyStimulus(1'b1, a, b, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k == 0) applyStimulus(1'b0, bus.op_a, bus.op_b, 1'b0, 1'b0, 32'h0);
      if (bus.mult_ctrl) ctrlCycles++;
      if (bus.busy) busyCycles++;
      if (disturb) begin
        if (k == 4) applyStimulus(1'b1, 32'd7, bus.op_b, 1'b0, 1'b0, 32'h0);
        else if (k == 5) applyStimulus(1'b0, 32'd7, bus.op_b, 1'b1, 1'b1, 32'h5A5A5A5A);
        else if (k == 6) applyStimulus(1'b0, 32'd7, bus.op_b, 1'b0, 1'b0, 32'h0);
        else if (k == 8) begin
          checkOutput("run hold hi", {32'h0, bus.hi}, {32'h0, modHi});
          checkOutput("run hold lo", {32'h0, bus.lo}, {32'h0, modLo});
          checkOutput("run hold mult_a", {32'h0, bus.mult_a}, {32'h0, a});
        end
      end
      if (bus.done) begin
        latency = k;
        if (chainNext) applyStimulus(1'b1, na, nb, 1'b0, 1'b0, 32'h0);
        break;
      end
    end
  endtask

  task automatic doMult(input logic [31:0] a, input logic [31:0] b, input bit disturb, input string tag);
    int c;
    int bc;
    int l;
    runMult(a, b, 1'b0, disturb, 1'b0, 32'h0, 32'h0, c, bc, l);
    {modHi, modLo} = refProduct(a, b);
    checkOutput({tag, " ctrl cycles"}, 64'(c), 64'd33);
    checkOutput({tag, " busy cycles"}, 64'(bc), 64'd34);
    checkOutput({tag, " done latency"}, 64'(l), 64'd34);
    checkOutput({tag, " hi"}, {32'h0, bus.hi}, {32'h0, modHi});
    checkOutput({tag, " lo"}, {32'h0, bus.lo}, {32'h0, modLo});
    tick();
    checkOutput({tag, " done once"}, {63'h0, bus.done}, 64'h0);
    checkOutput({tag, " no restart"}, {63'h0, bus.mult_ctrl}, 64'h0);
  endtask

  initial begin
    int c;
    int bc;
    int l;
    int l2;
    int doneSeen;
    logic [31:0] ra;
    logic [31:0] rb;
    errors = 0;
    checks = 0;
    modHi  = '0;
    modLo  = '0;
    reset  = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    checkOutput("reset hi", {32'h0, bus.hi}, 64'h0);
    checkOutput("reset lo", {32'h0, bus.lo}, 64'h0);
    checkOutput("reset busy", {63'h0, bus.busy}, 64'h0);
    checkOutput("reset mult_ctrl", {63'h0, bus.mult_ctrl}, 64'h0);
    checkOutput("reset done", {63'h0, bus.done}, 64'h0);
    checkOutput("reset mult_a", {32'h0, bus.mult_a}, 64'h0);

    doMult(32'd3, 32'd5, 1'b0, "3x5");
    doMult(32'hFFFFFFFE, 32'd3, 1'b0, "-2x3");

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h12345678);
    tick();
    modHi = 32'h12345678;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEBABE);
    checkOutput("mthi hi", {32'h0, bus.hi}, {32'h0, modHi});
    tick();
    modLo = 32'hCAFEBABE;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mtlo lo", {32'h0, bus.lo}, {32'h0, modLo});
    checkOutput("mtlo keeps hi", {32'h0, bus.hi}, {32'h0, modHi});
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0BADF00D);
    tick();
    modHi = 32'h0BADF00D;
    modLo = 32'h0BADF00D;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("both we hi", {32'h0, bus.hi}, {32'h0, modHi});
    checkOutput("both we lo", {32'h0, bus.lo}, {32'h0, modLo});

    doMult(32'h00001234, 32'hFFFF0001, 1'b1, "busy ignore");

    applyStimulus(1'b1, 32'd100, 32'd200, 1'b1, 1'b0, 32'h77777777);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("start+mthi hi", {32'h0, bus.hi}, 64'h77777777);
    checkOutput("start+mthi accepted", {63'h0, bus.mult_ctrl}, 64'h1);
    l = -1;
    for (int k = 1; k < 100; k++) begin
      tick();
      if (bus.done) begin
        l = k;
        break;
      end
    end
    {modHi, modLo} = refProduct(32'd100, 32'd200);
    checkOutput("start+mthi latency", 64'(l), 64'd34);
    checkOutput("start+mthi result hi", {32'h0, bus.hi}, {32'h0, modHi});
    checkOutput("start+mthi result lo", {32'h0, bus.lo}, {32'h0, modLo});
    tick();

    applyStimulus(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 10; k++) tick();
    applyStimulus(1'b1, 32'd9, 32'd9, 1'b1, 1'b1, 32'hFFFFFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    modHi = '0;
    modLo = '0;
    checkOutput("abort mult_ctrl", {63'h0, bus.mult_ctrl}, 64'h0);
    checkOutput("abort busy", {63'h0, bus.busy}, 64'h0);
    checkOutput("abort hi", {32'h0, bus.hi}, 64'h0);
    checkOutput("abort lo", {32'h0, bus.lo}, 64'h0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done || bus.mult_ctrl) doneSeen++;
    end
    checkOutput("abort no done", 64'(doneSeen), 64'h0);
    doMult(32'd3, 32'd5, 1'b0, "after abort");

    runMult(32'd7, 32'd9, 1'b0, 1'b0, 1'b1, 32'h10, 32'h10, c, bc, l);
    {modHi, modLo} = refProduct(32'd7, 32'd9);
    checkOutput("b2b first latency", 64'(l), 64'd34);
    checkOutput("b2b first lo", {32'h0, bus.lo}, {32'h0, modLo});
    runMult(32'h10, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, c, bc, l2);
    {modHi, modLo} = refProduct(32'h10, 32'h10);
    checkOutput("b2b done gap", 64'(l2 + 1), 64'd35);
    checkOutput("b2b ctrl cycles", 64'(c), 64'd33);
    checkOutput("b2b lo", {32'h0, bus.lo}, 64'h100);
    checkOutput("b2b hi", {32'h0, bus.hi}, {32'h0, modHi});
    tick();

    doMult(32'h80000000, 32'h80000000, 1'b0, "minxmin");
    doMult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "-1x-1");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      doMult(ra, rb, 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
